// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard detection and drain/halt sequencing for the
// 5-stage MIPS pipeline without forwarding. A scoreboard of destination
// registers in ID/EX, EX/MEM and MEM/WR stalls decode while a source operand
// is still in flight; a small FSM drains the pipe and halts on request.
// Optional build macro: PIPE_HAZARD_WRITE_FIRST_EN (write-before-read regfile,
// the MEM/WR entry no longer blocks a reader).
module pipe_hazard_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 3,
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_regwr,
    input  logic [ADDR_W-1:0] id_aw,
    input  logic              halt_req,
    output logic              stall,
    output logic              bubble,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_count
);

`ifdef PIPE_HAZARD_WRITE_FIRST_EN
    // MEM/WR writes the regfile before decode reads it in the same cycle.
    localparam int MATCH_N = DEPTH - 1;
`else
    localparam int MATCH_N = DEPTH;
`endif

    localparam int DC_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DRAIN_CYC);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Saturating increment: the counter holds at all ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DC_W-1:0]   r_dcnt;
    logic [DC_W-1:0]   w_dcnt_nxt;
    logic [DEPTH-1:0]  r_sb_vld;
    logic [ADDR_W-1:0] r_sb_addr [DEPTH];
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_hazard;
    logic w_stall;
    logic w_issue;
    logic w_sb_empty;

    // Compare decode sources against every tracked in-flight destination.
    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        for (int i = 0; i < MATCH_N; i++) begin
            if (r_sb_vld[i] && (r_sb_addr[i] == id_rs)) w_rs_hit = 1'b1;
            if (r_sb_vld[i] && (r_sb_addr[i] == id_rt)) w_rt_hit = 1'b1;
        end
        // $0 is hardwired to zero, so it never carries a dependency.
        w_rs_hit = w_rs_hit & id_uses_rs & (id_rs != '0);
        w_rt_hit = w_rt_hit & id_uses_rt & (id_rt != '0);
    end

    assign w_hazard   = id_valid & (w_rs_hit | w_rt_hit);
    assign w_stall    = w_hazard | (r_state != ST_RUN);
    assign w_issue    = id_valid & ~w_stall;
    assign w_sb_empty = ~(|r_sb_vld);

    assign stall       = w_stall;
    assign bubble      = w_stall;
    assign halted      = (r_state == ST_HALTED);
    assign stall_count = r_stall_cnt;

    // Next-state logic for the run / drain / halted sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            ST_RUN: begin
                // A halt request wins over a same-cycle hazard.
                if (halt_req) begin
                    w_state_nxt = ST_DRAIN;
                    w_dcnt_nxt  = DC_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    w_state_nxt = ST_RUN;
                end else if ((r_dcnt == '0) && w_sb_empty) begin
                    w_state_nxt = ST_HALTED;
                end else if (r_dcnt != '0) begin
                    w_dcnt_nxt = r_dcnt - DC_W'(1);
                end
            end
            ST_HALTED: begin
                if (!halt_req) w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Sequencer state and drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Scoreboard valid bits shift with the pipeline; a stall injects an empty slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_vld <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) r_sb_vld[i] <= r_sb_vld[i-1];
            r_sb_vld[0] <= w_issue & id_regwr & (id_aw != '0);
        end
    end

    // Scoreboard addresses travel alongside their valid bits; no reset needed.
    always_ff @(posedge clk) begin
        for (int i = DEPTH - 1; i > 0; i--) r_sb_addr[i] <= r_sb_addr[i-1];
        r_sb_addr[0] <= id_aw;
    end

    // Count hazard stalls only; drain and halt stalls are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_state == ST_RUN)) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

endmodule
